// File: rtl/sva_result_collector.sv
// sva_result_collector
//   Collects result pulses from an upstream SVA checker FSM: saturating
//   success / fail / lazy-success counters, a gclk-period timestamp, the
//   timestamp of the first fail, a small show-ahead event FIFO holding fail
//   and lazy-success events, a sticky overflow flag and a registered verdict.
//
// Ports
//   sys_clk        in   system clock, rising edge
//   sys_rst_n      in   asynchronous active-low reset
//   clr            in   synchronous clear of all state (beats every other event)
//   gclk_tick      in   one-cycle pulse per user-clock rising edge
//   succ/fail/lazy_succ in  result pulses
//   succ_cnt/fail_cnt/lazy_cnt out  saturating result counters
//   first_fail_vld out  first_fail_ts holds a captured value
//   first_fail_ts  out  timestamp of the first fail since reset/clr
//   evt_valid/evt_ready/evt_kind/evt_ts  event stream (kind 0=fail, 1=lazy)
//   ovf            out  sticky: an event was dropped on a full FIFO
//   verdict        out  00 none, 01 pass, 10 fail (sticky once fail)

module sva_result_collector #(
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 clr,
  input  logic                 gclk_tick,
  input  logic                 succ,
  input  logic                 fail,
  input  logic                 lazy_succ,
  input  logic                 evt_ready,
  output logic [CNT_WIDTH-1:0] succ_cnt,
  output logic [CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0] lazy_cnt,
  output logic                 first_fail_vld,
  output logic [TS_WIDTH-1:0]  first_fail_ts,
  output logic                 evt_valid,
  output logic                 evt_kind,
  output logic [TS_WIDTH-1:0]  evt_ts,
  output logic                 ovf,
  output logic [1:0]           verdict
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------------
  // Timestamp
  // ---------------------------------------------------------------------
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ts <= '0;
    end else if (clr) begin
      r_ts <= '0;
    end else if (gclk_tick) begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Saturating counters: index 0 = succ, 1 = fail, 2 = lazy
  // ---------------------------------------------------------------------
  logic [2:0]           w_pulse;
  logic [CNT_WIDTH-1:0] r_cnt [0:2];

  assign w_pulse = {lazy_succ, fail, succ};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_cnt[gi] <= '0;
        end else if (clr) begin
          r_cnt[gi] <= '0;
        end else if (w_pulse[gi] && !(&r_cnt[gi])) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign succ_cnt = r_cnt[0];
  assign fail_cnt = r_cnt[1];
  assign lazy_cnt = r_cnt[2];

  // ---------------------------------------------------------------------
  // First-fail capture
  // ---------------------------------------------------------------------
  logic                r_first_fail_vld;
  logic [TS_WIDTH-1:0] r_first_fail_ts;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_first_fail_vld <= 1'b0;
      r_first_fail_ts  <= '0;
    end else if (clr) begin
      r_first_fail_vld <= 1'b0;
      r_first_fail_ts  <= '0;
    end else if (fail && !r_first_fail_vld) begin
      r_first_fail_vld <= 1'b1;
      r_first_fail_ts  <= r_ts;   // pre-increment timestamp
    end
  end

  assign first_fail_vld = r_first_fail_vld;
  assign first_fail_ts  = r_first_fail_ts;

  // ---------------------------------------------------------------------
  // Event FIFO (show-ahead); entry = {kind, ts}
  // ---------------------------------------------------------------------
  logic [TS_WIDTH:0] r_mem [0:FIFO_DEPTH-1];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_ovf;
  logic              w_empty;
  logic              w_full;
  logic              w_push_req;
  logic              w_pop;
  logic              w_push;
  logic [TS_WIDTH:0] w_wr_data;
  logic [TS_WIDTH:0] w_head;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_req = fail | lazy_succ;
  assign w_pop      = !w_empty && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = w_push_req && (!w_full || w_pop);
  // Fail wins when both arrive together: kind = 0 whenever fail is set.
  assign w_wr_data  = {~fail, r_ts};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge sys_clk) begin
    if (!clr && w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
    end
  end

  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign evt_valid = !w_empty;
  assign evt_kind  = w_empty ? 1'b0 : w_head[TS_WIDTH];
  assign evt_ts    = w_empty ? '0 : w_head[TS_WIDTH-1:0];
  assign ovf       = r_ovf;

  // ---------------------------------------------------------------------
  // Verdict: follows the counters one cycle later; fail is terminal
  // ---------------------------------------------------------------------
  logic [1:0] r_verdict;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_verdict <= 2'b00;
    end else if (clr) begin
      r_verdict <= 2'b00;
    end else if (r_verdict == 2'b10 || r_cnt[1] != '0) begin
      r_verdict <= 2'b10;
    end else if (r_cnt[0] != '0) begin
      r_verdict <= 2'b01;
    end else begin
      r_verdict <= 2'b00;
    end
  end

  assign verdict = r_verdict;

endmodule

// File: doc/sva_result_collector.md
SVA_RESULT_COLLECTOR -- requirements
Module: sva_result_collector

Interface
REQ-001 Parameter: CNT_WIDTH, default 16, width of each result counter.
REQ-002 Parameter: TS_WIDTH, default 16, width of the gclk-period timestamp.
REQ-003 Parameter: FIFO_DEPTH, default 4, event FIFO entries; the value SHALL be a power of 2 and at least 2.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 sys_clk  in  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-006 sys_rst_n  in  1  asynchronous active-low reset.
REQ-007 clr  in  1  synchronous clear of all state.
REQ-008 gclk_tick  in  1  one-cycle pulse per user-clock rising edge (the gclk posedge flag).
REQ-009 succ, fail, lazy_succ  in  1 each  result pulses from the upstream SVA checker FSM.
REQ-010 succ_cnt, fail_cnt, lazy_cnt  out  CNT_WIDTH each  result counters.
REQ-011 first_fail_vld  out  1  set when first_fail_ts holds a captured value.
REQ-012 first_fail_ts  out  TS_WIDTH  timestamp of the first fail since reset or clr.
REQ-013 evt_valid  out  1; evt_ready  in  1; evt_kind  out  1 (0=fail, 1=lazy); evt_ts  out  TS_WIDTH.
REQ-014 ovf  out  1  sticky flag: an event was dropped.
REQ-015 verdict  out  2  00=none, 01=pass, 10=fail.

Function
REQ-016 ts counter SHALL increment by 1 on each sys_clk cycle with gclk_tick=1, wrapping from all-ones to 0.
REQ-017 Event timestamp SHALL be the ts value before any same-cycle increment.
REQ-018 Each counter SHALL increment by 1 in a cycle where its pulse is 1; counters saturate at all-ones and never wrap.
REQ-019 Simultaneous pulses SHALL each be counted in the same cycle.
REQ-020 On the first fail pulse, first_fail_ts SHALL capture the event timestamp and first_fail_vld SHALL go 1 the next cycle.
REQ-021 Later fails SHALL NOT change first_fail_ts.
REQ-022 A fail or lazy_succ pulse SHALL request a FIFO push.
REQ-023 If fail and lazy_succ coincide, only the fail SHALL be enqueued; lazy_succ is still counted.
REQ-024 FIFO SHALL be show-ahead.
REQ-025 evt_valid SHALL equal not-empty; evt_kind and evt_ts SHALL present the head entry.
REQ-026 A pop SHALL occur when evt_valid and evt_ready are both 1.
REQ-027 Push while full without a same-cycle pop SHALL drop the entry and set ovf.
REQ-028 Push while full with a same-cycle pop SHALL be accepted.
REQ-029 Push to an empty FIFO SHALL make evt_valid 1 on the following cycle, a latency of 1.
REQ-030 Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits; full is when the MSBs differ and the low bits are equal.
REQ-031 verdict SHALL be registered: 10 if fail_cnt is non-zero, else 01 if succ_cnt is non-zero, else 00.
REQ-032 verdict SHALL update one cycle after the counter change.
REQ-033 Once verdict is 10, it SHALL stay 10 until reset or clr.
REQ-034 clr SHALL return all state to reset values at the next edge.
REQ-035 clr SHALL take priority over same-cycle pulses, ticks and pops; those events are discarded.

Reset
REQ-036 While sys_rst_n=0, all outputs SHALL be 0: counters, ts, first_fail_vld, first_fail_ts, evt_valid, ovf and verdict.
REQ-037 While sys_rst_n=0, the FIFO SHALL be empty and pointers 0.
REQ-038 Reset assertion mid-operation SHALL discard queued events immediately, without waiting for a clock edge.
REQ-039 Deassertion SHALL take effect at the first sys_clk edge where sys_rst_n=1.

Verification
REQ-040 Scenario 1: 3 gclk_ticks, then succ pulse -> succ_cnt=1, verdict=01, evt_valid stays 0.
REQ-041 Scenario 2: 5 ticks, then fail; 2 more ticks, then fail -> first_fail_ts=5, fail_cnt=2, FIFO holds (0,5),(0,7), verdict=10.
REQ-042 Scenario 3: fail and lazy_succ in the same cycle at ts=2 -> fail_cnt=1, lazy_cnt=1, exactly one entry (0,2) queued.
REQ-043 Scenario 4: evt_ready=0, 5 fail pulses with FIFO_DEPTH=4 -> 4 entries held, ovf=1, fail_cnt=5.
REQ-044 Scenario 4 continued: then evt_ready=1 with fail in the same cycle -> push accepted, ovf remains 1.
REQ-045 Scenario 5: CNT_WIDTH=2, 5 succ pulses -> succ_cnt saturates at 3.
REQ-046 Scenario 6: FIFO non-empty, then sys_rst_n pulsed low mid-cycle -> all outputs 0 immediately.
REQ-047 Scenario 6 continued: clr with a coincident fail -> fail_cnt=0, verdict=00.
